bist_signature_analyzer: RTL and testbench

Output-response end of the scan BIST path. It sequences shift and capture for the 7 scan chains of the s9234 CUT and compacts the 7 scan-out streams into a 7-bit MISR. At end of test it compares the signature against a golden value and flags pass/fail. It sits beside the LFSR TPG. Its scan_en_out drives the CUT scan_en, and its so_in is {SO_chain7..SO_chain1}.

---
 rtl/bist_signature_analyzer.sv | 98 +++++++++
 tb/tb_bist_signature_analyzer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bist_signature_analyzer.sv
// Output-response end of the scan BIST path. Sequences shift/capture for the
// CUT scan chains and compacts the scan-out streams into a 7-bit MISR
// (x^7+x^6+1). At end of test the signature is compared against GOLDEN.
//
// Ports:
//   CK            clock, all flops on posedge
//   COMP_reset_n  asynchronous active-low reset
//   start         one-cycle pulse, honoured in IDLE and DONE only
//   so_in[6:0]    scan-out bits, so_in[i] = SO_chain(i+1)
//   scan_en_out   1 = shift, 0 = capture (drives CUT scan_en)
//   busy          high in SHIFT or CAPTURE
//   done          high in DONE
//   pass          valid while done; 1 iff signature == GOLDEN
//   signature     current MISR contents
module bist_signature_analyzer #(
  parameter int         CHAIN_LEN    = 33,
  parameter int         NUM_PATTERNS = 100,
  parameter logic [6:0] GOLDEN       = 7'h00
) (
  input  logic       CK,
  input  logic       COMP_reset_n,
  input  logic       start,
  input  logic [6:0] so_in,
  output logic       scan_en_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] signature
);

  localparam int SW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int PW = (NUM_PATTERNS > 0) ? $clog2(NUM_PATTERNS + 1) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, DONE} state_e;

  state_e          state_q, state_d;
  logic [6:0]      misr_q, misr_d, misr_nxt;
  logic [SW-1:0]   shift_cnt_q, shift_cnt_d;
  logic [PW-1:0]   pat_cnt_q, pat_cnt_d;

  // One MISR step with the current scan-out slice folded in.
  assign misr_nxt[0]   = misr_q[6] ^ so_in[0];
  assign misr_nxt[5:1] = misr_q[4:0] ^ so_in[5:1];
  assign misr_nxt[6]   = misr_q[6] ^ misr_q[5] ^ so_in[6];

  always_ff @(posedge CK or negedge COMP_reset_n) begin
    if (!COMP_reset_n) begin
      state_q     <= IDLE;
      misr_q      <= 7'h00;
      shift_cnt_q <= '0;
      pat_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      misr_q      <= misr_d;
      shift_cnt_q <= shift_cnt_d;
      pat_cnt_q   <= pat_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    misr_d      = misr_q;
    shift_cnt_d = shift_cnt_q;
    pat_cnt_d   = pat_cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = SHIFT;
          misr_d      = 7'h00;
          shift_cnt_d = '0;
          pat_cnt_d   = '0;
        end
      end
      SHIFT: begin
        // Window 0 unloads unknown power-up CUT state, so it is not compacted.
        if (pat_cnt_q != '0) misr_d = misr_nxt;
        if (shift_cnt_q == SW'(CHAIN_LEN - 1)) begin
          shift_cnt_d = '0;
          state_d     = (pat_cnt_q == PW'(NUM_PATTERNS)) ? DONE : CAPTURE;
        end else begin
          shift_cnt_d = shift_cnt_q + SW'(1);
        end
      end
      CAPTURE: begin
        pat_cnt_d = pat_cnt_q + PW'(1);
        state_d   = SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end

  assign scan_en_out = (state_q == SHIFT);
  assign busy        = (state_q == SHIFT) || (state_q == CAPTURE);
  assign done        = (state_q == DONE);
  assign pass        = (state_q == DONE) && (misr_q == GOLDEN);
  assign signature   = misr_q;

endmodule

// File: tb/tb_bist_signature_analyzer.sv
module tb_bist_signature_analyzer;
  localparam int L   = 4;
  localparam int P   = 2;
  localparam int RUN = (P + 1) * L + P;  // 14 busy cycles

  logic       CK = 1'b0;
  logic       COMP_reset_n;
  logic       start;
  logic [6:0] so_in;
  logic       scan_en_out, busy, done, pass;
  logic [6:0] signature;
  logic       scan_en_b, busy_b, done_b, pass_b;
  logic [6:0] signature_b;

  bist_signature_analyzer #(.CHAIN_LEN(L), .NUM_PATTERNS(P), .GOLDEN(7'h00)) dut_a (
    .CK(CK), .COMP_reset_n(COMP_reset_n), .start(start), .so_in(so_in),
    .scan_en_out(scan_en_out), .busy(busy), .done(done), .pass(pass),
    .signature(signature));

  bist_signature_analyzer #(.CHAIN_LEN(L), .NUM_PATTERNS(P), .GOLDEN(7'h41)) dut_b (
    .CK(CK), .COMP_reset_n(COMP_reset_n), .start(start), .so_in(so_in),
    .scan_en_out(scan_en_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .signature(signature_b));

  always #5 CK = ~CK;

  int cyc = 0;
  always @(posedge CK) cyc <= cyc + 1;

  typedef struct {
    logic [6:0] sig;
    logic       p0;
    logic       p41;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [6:0] stim[RUN];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: run is P+1 windows of L shifts, a capture between windows.
  // Only shift cycles of windows 1..P are folded into the signature.
  function automatic logic [6:0] misr_step(input logic [6:0] q, input logic [6:0] s);
    logic [6:0] t;
    t    = {q[5:0], q[6]} ^ s;   // rotate left, feedback into bit 0
    t[6] = t[6] ^ q[6];          // x^6 tap
    return t;
  endfunction

  function automatic bit is_shift(input int k);
    return (k % (L + 1)) < L;
  endfunction

  function automatic logic [6:0] model_sig();
    logic [6:0] q = 7'h00;
    for (int k = 0; k < RUN; k++)
      if (is_shift(k) && (k / (L + 1)) > 0) q = misr_step(q, stim[k]);
    return q;
  endfunction

  // Monitor: a completed run is presented by the rising edge of done.
  initial begin
    logic done_d = 1'b0;
    exp_t e;
    forever begin
      @(negedge CK);
      if (done && !done_d) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_done: got done=1 expected no run");
        end else begin
          e = exp_q.pop_front();
          chk("signature", {25'd0, signature}, {25'd0, e.sig});
          chk("pass_g00", {31'd0, pass}, {31'd0, e.p0});
          chk("pass_g41", {31'd0, pass_b}, {31'd0, e.p41});
          chk("sig_b", {25'd0, signature_b}, {25'd0, e.sig});
          chk("done_b", {31'd0, done_b}, 32'd1);
          chk("run_len", cyc, e.cyc);
        end
      end
      done_d = done;
    end
  end

  task automatic run(input int glitch_k);
    exp_t e;
    logic [6:0] q;
    q     = model_sig();
    @(posedge CK); #1;
    e.sig = q; e.p0 = (q == 7'h00); e.p41 = (q == 7'h41); e.cyc = cyc + RUN + 1;
    exp_q.push_back(e);
    start = 1'b1;
    so_in = 7'($urandom);
    @(posedge CK); #1;
    start = 1'b0;
    for (int k = 0; k < RUN; k++) begin
      so_in = stim[k];
      start = (k == glitch_k);
      @(negedge CK);
      chk("busy", {31'd0, busy}, 32'd1);
      chk("scan_en", {31'd0, scan_en_out}, {31'd0, is_shift(k)});
      chk("done_low", {31'd0, done}, 32'd0);
      chk("pass_low", {31'd0, pass}, 32'd0);
      if (k == 0) chk("misr_clear", {25'd0, signature}, 32'd0);
      @(posedge CK); #1;
      start = 1'b0;
    end
    so_in = 7'h00;
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge CK);
    if (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL done_timeout: got done=%0b expected done=1", done);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic fill(input logic [6:0] v);
    for (int k = 0; k < RUN; k++) stim[k] = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    COMP_reset_n = 1'b0;
    start        = 1'b0;
    so_in        = 7'h00;
    #12;
    chk("rst_scan_en", {31'd0, scan_en_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_sig", {25'd0, signature}, 32'd0);
    @(posedge CK); #1;
    COMP_reset_n = 1'b1;
    repeat (2) @(posedge CK);
    @(negedge CK);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // zeros throughout
    fill(7'h00);
    run(-1);
    // all-ones only in window 0 is discarded
    fill(7'h00);
    for (int k = 0; k < L; k++) stim[k] = 7'h7F;
    run(-1);
    // single bit on the first compacted cycle -> 7'h41
    fill(7'h00);
    stim[L + 1] = 7'h01;
    run(-1);
    // all-ones only during capture cycles; start glitch in SHIFT
    fill(7'h00);
    stim[L] = 7'h7F;
    stim[2 * L + 1] = 7'h7F;
    run(2);
    // randomized runs, start glitches in shift and capture
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < RUN; k++) stim[k] = 7'($urandom);
      run((r % 2 == 0) ? L : $urandom_range(RUN - 1, 0));
    end

    // reset mid-SHIFT of window 1
    @(posedge CK); #1;
    start = 1'b1;
    @(posedge CK); #1;
    start = 1'b0;
    for (int k = 0; k < L + 3; k++) begin
      so_in = 7'($urandom);
      @(posedge CK); #1;
    end
    #2;
    COMP_reset_n = 1'b0;
    #1;
    chk("arst_scan_en", {31'd0, scan_en_out}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_pass", {31'd0, pass}, 32'd0);
    chk("arst_sig", {25'd0, signature}, 32'd0);
    @(posedge CK); #1;
    COMP_reset_n = 1'b1;
    so_in = 7'h55;
    repeat (RUN + 4) @(posedge CK);
    @(negedge CK);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_done", {31'd0, done}, 32'd0);
    chk("post_rst_sig", {25'd0, signature}, 32'd0);

    // a fresh run from IDLE after reset
    for (int k = 0; k < RUN; k++) stim[k] = 7'($urandom);
    run(-1);

    repeat (2) @(posedge CK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
